// File: rtl/magic_square_gen_pkg.sv
// rtl/magic_square_gen_pkg.sv - shared states, constants and range helpers for magic_square_gen
package magic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int CELLS = 9;

  localparam int SYM_TRANSPOSE = 0;
  localparam int SYM_MIRROR_LR = 1;
  localparam int SYM_MIRROR_TB = 2;

  function automatic int unsigned magic_const(input int unsigned base);
    return 3 * base + 12;
  endfunction

  // Both the largest cell and the line sum must fit in w bits.
  function automatic logic range_ok(input int unsigned base, input int unsigned w);
    int unsigned lim;
    lim = (32'd1 << w) - 32'd1;
    return (base + 8 <= lim) && (3 * base + 12 <= lim);
  endfunction

endpackage

// File: rtl/magic_square_gen_siamese_step.sv
// rtl/magic_square_gen_siamese_step.sv - next (row,col) of the Siamese up-right walk on a 3x3 board
module siamese_step (
  input  logic [1:0] row,
  input  logic [1:0] col,
  input  logic [3:0] k,
  output logic [1:0] next_row,
  output logic [1:0] next_col
);

  logic move_down;

  // After every third value the up-right cell is already taken, so step down instead.
  assign move_down = (k == 4'd2) || (k == 4'd5) || (k == 4'd8);

  always_comb begin
    next_row = row;
    next_col = col;
    if (move_down) begin
      next_row = (row == 2'd2) ? 2'd0 : row + 2'd1;
    end else begin
      next_row = (row == 2'd0) ? 2'd2 : row - 2'd1;
      next_col = (col == 2'd2) ? 2'd0 : col + 2'd1;
    end
  end

endmodule

// File: rtl/magic_square_gen.sv
// rtl/magic_square_gen.sv - Siamese 3x3 magic square generator with symmetry select and valid/ready output
// Optional MAGIC_SELFCHECK_EN adds a CHECK state verifying all eight line sums before output.
module magic_square_gen
  import magic_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_L,
  input  logic         start,
  input  logic [W-1:0] base,
  input  logic [2:0]   sym,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] num1,
  output logic [W-1:0] num2,
  output logic [W-1:0] num3,
  output logic [W-1:0] num4,
  output logic [W-1:0] num5,
  output logic [W-1:0] num6,
  output logic [W-1:0] num7,
  output logic [W-1:0] num8,
  output logic [W-1:0] num9,
  output logic [W-1:0] magic_constant,
  output logic         err
);

  state_t       state, state_next;
  logic         err_next;
  logic [W-1:0] base_q;
  logic [2:0]   sym_q;
  logic [3:0]   k;
  logic [1:0]   row, col, next_row, next_col;
  logic [3:0]   wr_idx;
  logic         out_valid_q;
  logic [W-1:0] cells  [CELLS];
  logic [W-1:0] mapped [CELLS];
  logic [W-1:0] num_q  [CELLS];

  siamese_step u_step (
    .row      (row),
    .col      (col),
    .k        (k),
    .next_row (next_row),
    .next_col (next_col)
  );

  assign wr_idx = {2'b00, row} * 4'd3 + {2'b00, col};

  // Output (r,c) pulls from the cell reached by undoing TB, then LR, then transpose.
  always_comb begin
    int rr, cc, src;
    mapped = '{default: '0};
    rr = 0;
    cc = 0;
    src = 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        rr = sym_q[SYM_MIRROR_TB] ? 2 - r : r;
        cc = sym_q[SYM_MIRROR_LR] ? 2 - c : c;
        src = sym_q[SYM_TRANSPOSE] ? cc * 3 + rr : rr * 3 + cc;
        mapped[r*3+c] = cells[src];
      end
    end
  end

`ifdef MAGIC_SELFCHECK_EN
  logic         sums_ok;
  logic [W+1:0] mc_wide;

  function automatic logic [W+1:0] add3(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] c);
    return (W+2)'(a) + (W+2)'(b) + (W+2)'(c);
  endfunction

  always_comb begin
    mc_wide = (W+2)'(magic_const(32'(base_q)));
    sums_ok = (add3(cells[0], cells[1], cells[2]) == mc_wide) &&
              (add3(cells[3], cells[4], cells[5]) == mc_wide) &&
              (add3(cells[6], cells[7], cells[8]) == mc_wide) &&
              (add3(cells[0], cells[3], cells[6]) == mc_wide) &&
              (add3(cells[1], cells[4], cells[7]) == mc_wide) &&
              (add3(cells[2], cells[5], cells[8]) == mc_wide) &&
              (add3(cells[0], cells[4], cells[8]) == mc_wide) &&
              (add3(cells[2], cells[4], cells[6]) == mc_wide);
  end
`endif

  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (range_ok(32'(base), W)) state_next = FILL;
          else err_next = 1'b1;
        end
      end
      FILL: begin
        if (k == 4'd8) begin
`ifdef MAGIC_SELFCHECK_EN
          state_next = CHECK;
`else
          state_next = OUT;
`endif
        end
      end
`ifdef MAGIC_SELFCHECK_EN
      CHECK: begin
        if (sums_ok) begin
          state_next = OUT;
        end else begin
          state_next = IDLE;
          err_next   = 1'b1;
        end
      end
`endif
      OUT: begin
        if (out_valid_q && out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state          <= IDLE;
      err            <= 1'b0;
      base_q         <= '0;
      sym_q          <= '0;
      k              <= '0;
      row            <= '0;
      col            <= '0;
      out_valid_q    <= 1'b0;
      magic_constant <= '0;
      cells          <= '{default: '0};
      num_q          <= '{default: '0};
    end else begin
      state <= state_next;
      err   <= err_next;
      case (state)
        IDLE: begin
          if (start && range_ok(32'(base), W)) begin
            base_q <= base;
            sym_q  <= sym;
            k      <= '0;
            row    <= 2'd0;
            col    <= 2'd1;
            cells  <= '{default: '0};
          end
        end
        FILL: begin
          cells[wr_idx] <= base_q + W'(k);
          k             <= k + 4'd1;
          row           <= next_row;
          col           <= next_col;
        end
        OUT: begin
          // First OUT cycle registers the mapped square; valid rises with it.
          if (!out_valid_q) begin
            num_q          <= mapped;
            magic_constant <= W'(magic_const(32'(base_q)));
            out_valid_q    <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign out_valid = out_valid_q;
  assign num1      = num_q[0];
  assign num2      = num_q[1];
  assign num3      = num_q[2];
  assign num4      = num_q[3];
  assign num5      = num_q[4];
  assign num6      = num_q[5];
  assign num7      = num_q[6];
  assign num8      = num_q[7];
  assign num9      = num_q[8];

endmodule

// File: tb/tb_magic_square_gen.sv
// tb/tb_magic_square_gen.sv - directed self-checking bench for magic_square_gen
module tb_magic_square_gen;

  localparam int W = 4;
`ifdef MAGIC_SELFCHECK_EN
  localparam int LAT = 11;
`else
  localparam int LAT = 10;
`endif

  logic         clock;
  logic         reset_L;
  logic         start;
  logic [W-1:0] base;
  logic [2:0]   sym;
  logic         busy;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] num1, num2, num3, num4, num5, num6, num7, num8, num9;
  logic [W-1:0] magic_constant;
  logic         err;
  logic [35:0]  vec;

  int checks   = 0;
  int failures = 0;

  magic_square_gen #(.W(W)) dut (
    .clock          (clock),
    .reset_L        (reset_L),
    .start          (start),
    .base           (base),
    .sym            (sym),
    .busy           (busy),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .num1           (num1),
    .num2           (num2),
    .num3           (num3),
    .num4           (num4),
    .num5           (num5),
    .num6           (num6),
    .num7           (num7),
    .num8           (num8),
    .num9           (num9),
    .magic_constant (magic_constant),
    .err            (err)
  );

  assign vec = {num1, num2, num3, num4, num5, num6, num7, num8, num9};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_square(input logic [3:0] b, input logic [2:0] s, input logic [35:0] exp_vec,
                            input logic [3:0] exp_mc, input string name);
    int n;
    start = 1'b1;
    base = b;
    sym = s;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== LAT) begin
      failures++;
      $display("FAIL %s latency: got %0d want %0d", name, n, LAT);
    end
    checks++;
    if (vec !== exp_vec) begin
      failures++;
      $display("FAIL %s square: got %h want %h", name, vec, exp_vec);
    end
    checks++;
    if (magic_constant !== exp_mc) begin
      failures++;
      $display("FAIL %s magic_constant: got %0d want %0d", name, magic_constant, exp_mc);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s after handshake: out_valid=%b busy=%b want 0 0", name, out_valid, busy);
    end
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    start = 1'b0;
    base = '0;
    sym = '0;
    out_ready = 1'b0;
    repeat (2) tick();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset flags: busy=%b out_valid=%b err=%b want 0 0 0", busy, out_valid, err);
    end
    checks++;
    if (vec !== 36'h0 || magic_constant !== 4'd0) begin
      failures++;
      $display("FAIL reset data: cells=%h mc=%0d want 0 0", vec, magic_constant);
    end
    reset_L = 1'b1;
    tick();
  endtask

  task automatic test_canonical();
    run_square(4'd1, 3'b000, 36'h816357492, 4'd15, "canonical");
  endtask

  task automatic test_transpose();
    run_square(4'd0, 3'b001, 36'h723048561, 4'd12, "transpose_base0");
  endtask

  task automatic test_sym_sweep();
    logic [35:0] tbl [8];
    tbl[0] = 36'h816357492;
    tbl[1] = 36'h834159672;
    tbl[2] = 36'h618753294;
    tbl[3] = 36'h438951276;
    tbl[4] = 36'h492357816;
    tbl[5] = 36'h672159834;
    tbl[6] = 36'h294753618;
    tbl[7] = 36'h276951438;
    for (int i = 0; i < 8; i++) begin
      run_square(4'd1, 3'(i), tbl[i], 4'd15, $sformatf("sym%0d", i));
    end
  endtask

  task automatic test_range_error();
    logic bad;
    start = 1'b1;
    base = 4'd2;
    sym = 3'b000;
    tick();
    start = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL range_err pulse: err=%b busy=%b want 1 0", err, busy);
    end
    tick();
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL range_err width: err=%b want 0", err);
    end
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL range_err idle: activity seen, want none");
    end
    checks++;
    if (vec !== 36'h276951438 || magic_constant !== 4'd15) begin
      failures++;
      $display("FAIL range_err hold: cells=%h mc=%0d want 276951438 15", vec, magic_constant);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic bad;
    out_ready = 1'b0;
    start = 1'b1;
    base = 4'd0;
    sym = 3'b001;
    tick();
    start = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== LAT) begin
      failures++;
      $display("FAIL backpressure latency: got %0d want %0d", n, LAT);
    end
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      start = i[0];
      base = 4'($urandom);
      sym = 3'($urandom);
      tick();
      if (out_valid !== 1'b1 || busy !== 1'b1 || vec !== 36'h723048561 || magic_constant !== 4'd12)
        bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL backpressure hold: outputs moved, want 723048561 mc 12 valid");
    end
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || vec !== 36'h723048561) begin
      failures++;
      $display("FAIL handshake: out_valid=%b busy=%b cells=%h want 0 0 723048561",
               out_valid, busy, vec);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL start at handshake: busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid_fill();
    start = 1'b1;
    base = 4'd1;
    sym = 3'b000;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    reset_L = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || vec !== 36'h0 || magic_constant !== 4'd0) begin
      failures++;
      $display("FAIL reset mid-fill: busy=%b out_valid=%b cells=%h mc=%0d want 0 0 0 0",
               busy, out_valid, vec, magic_constant);
    end
    tick();
    reset_L = 1'b1;
    tick();
    run_square(4'd1, 3'b000, 36'h816357492, 4'd15, "after_reset");
  endtask

  initial begin
    test_reset();
    test_canonical();
    test_transpose();
    test_sym_sweep();
    test_range_error();
    test_back_to_back();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/magic_square_gen.md
Name: magic_square_gen

Overview:
- Sequential producer of 3x3 magic squares: builds a square of the consecutive values base..base+8 using the Siamese (up-right) method, one cell per clock.
- Applies one of 8 board symmetries, then presents nine row-major cells plus the magic constant on a valid/ready output.
- Sits upstream of the team's combinational magic-square checker and feeds its num1..num9 inputs. Used as the stimulus source for that checker and as a demo generator.

Parameters:
- W, 4, cell/sum width in bits. Matches the checker's 4-bit datapath.

Ports:
- clock  in  1  system clock; all state on rising edge
- reset_L  in  1  asynchronous, active-low reset
- start  in  1  request generation; sampled only in IDLE
- base  in  W  smallest value placed in the square
- sym  in  3  symmetry select, latched with start: bit0 transpose, bit1 mirror left-right, bit2 mirror top-bottom; applied in order bit0, bit1, bit2
- busy  out  1  high in FILL and OUT
- out_valid  out  1  square available
- out_ready  in  1  consumer accepts square
- num1..num9  out  W each  cells in row-major order (num1 top-left, num9 bottom-right)
- magic_constant  out  W  3*base+12
- err  out  1  one-cycle pulse: request rejected (range error)

Behaviour:
- Reset (async, reset_L=0): state=IDLE. busy, out_valid and err are 0. All cell registers, num1..num9 and magic_constant are 0. Reset mid-FILL or mid-OUT aborts without any output.
- States: IDLE, FILL, OUT.
- IDLE, start=1: latch base and sym, then range-check.
  - Legal iff base+8 <= 2^W-1 and 3*base+12 <= 2^W-1, computed in W+2 bits. With W=4 only base 0 or 1 is legal.
  - Illegal: err=1 for exactly the next cycle, stay in IDLE, cells unchanged.
  - Legal: clear the 9 cells, set k=0, pos=(row0,col1), go to FILL.
- FILL: one cell per cycle. Write base+k at pos, then k++.
  - Next pos, when (k+1) mod 3 == 0: (row+1 mod 3, col), i.e. move down.
  - Otherwise: (row-1 mod 3, col+1 mod 3). Both coordinates wrap.
  - After the write of k=8, go to OUT. FILL lasts exactly 9 cycles.
- OUT: out_valid=1.
  - num1..num9 = symmetry-mapped cells. Mapping is combinational from the registered cells and the latched sym.
  - magic_constant = 3*base+12, truncated to W (legal range guarantees no loss).
  - All outputs hold stable while out_valid=1 and out_ready=0.
  - out_valid & out_ready on an edge: go to IDLE, out_valid=0 next cycle. num* and magic_constant hold their last values.
- Latency: out_valid rises exactly 10 rising edges after the edge that samples start in IDLE.
- start in FILL or OUT is ignored; no queuing. A start asserted in the same cycle as the OUT handshake is ignored; the earliest accepted start is the following cycle in IDLE.
- out_ready is ignored outside OUT.

Optional Feature:
- Macro: MAGIC_SELFCHECK_EN.
- With it: on entering OUT, first spend one extra cycle (state CHECK) recomputing 3 rows, 3 cols and 2 diagonals in W+2 bits and comparing each to 3*base+12.
  - All match: go to OUT (latency becomes 11).
  - Any mismatch: pulse err, go to IDLE, never assert out_valid.
- Without it: no CHECK state, latency 10, no self-check logic synthesized.

Decomposition:
- Package magic_pkg:
  - state enum (IDLE, FILL, CHECK, OUT)
  - CELLS=9
  - sym bit-position constants
  - function magic_const(base)
  - function range_ok(base)
- Sub-module siamese_step: combinational next-(row,col) from current (row,col) and k. Instantiated once.

Test Plan:
- Canonical square: base=1, sym=0, start pulse, out_ready=1 -> exactly 10 cycles later out_valid=1 with rows 8 1 6 / 3 5 7 / 4 9 2, magic_constant=15; out_valid=0 next cycle.
- Transpose and offset: base=0, sym=3'b001 -> rows 7 2 3 / 0 4 8 / 5 6 1, magic_constant=12.
- Symmetry sweep: base=1, all 8 sym values -> 8 distinct squares, each passing the checker with it_is_magic=1; sym=3'b110 gives 2 9 4 / 7 5 3 / 6 1 8.
- Range error: base=2 at W=4 -> err high exactly one cycle, busy=0, out_valid never rises, cells unchanged.
- Backpressure and ignored start: hold out_ready=0 for 20 cycles while toggling start, base and sym -> outputs stable, no restart. Then out_ready=1 -> handshake, IDLE.
- Reset mid-FILL: drop reset_L at FILL cycle 4 -> immediately busy=0, out_valid=0, num*=0. A fresh start after release gives the correct square at the correct latency.
